// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
package wb_pkg;

  localparam int XLEN              = 32;
  localparam int REG_ADDR_W        = 5;
  localparam int WB_DEPTH_DEF      = 4;
  localparam int WB_STARVE_MAX_DEF = 8;

  // One pending writeback: destination register plus result value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // Arbitration state: normal ALU priority, or a single forced LSU slot.
  typedef enum logic {
    ALU_PRI   = 1'b0,
    LSU_FORCE = 1'b1
  } wb_arb_state_e;

  // x0 is hardwired to zero, so results aimed at it are consumed silently.
  function automatic logic wb_writes(input logic [REG_ADDR_W-1:0] rd);
    return (rd != '0);
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Bundle of the ALU/LSU result channels and the register-file write port.
interface writeback_arbiter_if #(
  parameter int XLEN  = wb_pkg::XLEN,
  parameter int DEPTH = wb_pkg::WB_DEPTH_DEF
);

  localparam int RA_W  = wb_pkg::REG_ADDR_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             alu_valid;
  logic             alu_ready;
  logic [RA_W-1:0]  alu_rd;
  logic [XLEN-1:0]  alu_data;

  logic             lsu_valid;
  logic             lsu_ready;
  logic [RA_W-1:0]  lsu_rd;
  logic [XLEN-1:0]  lsu_data;

  logic             write_enable;
  logic [RA_W-1:0]  write_reg;
  logic [XLEN-1:0]  write_data;

  logic [CNT_W-1:0] lsu_count;

  // Producer / register-file side.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready,
    input  write_enable, write_reg, write_data, lsu_count
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready,
    output write_enable, write_reg, write_data, lsu_count
  );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer holding load results until they win the write port.
// Push and pop requests are ignored when full / empty respectively.
module wb_fifo #(
  parameter int DEPTH = wb_pkg::WB_DEPTH_DEF,
  parameter int WIDTH = $bits(wb_pkg::wb_entry_t)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_FULL);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop  && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Pointer and occupancy tracking; power-of-two depth gives natural wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Single-port register-file writeback arbiter. ALU results pass straight
// through when they win; load results queue in a FIFO. The FIFO head wins
// when the FIFO is full or after the LSU has lost STARVE_MAX arbitrations
// in a row. The write port is registered (one cycle after grant).
module writeback_arbiter #(
  parameter int XLEN       = wb_pkg::XLEN,
  parameter int DEPTH      = wb_pkg::WB_DEPTH_DEF,
  parameter int STARVE_MAX = wb_pkg::WB_STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  writeback_arbiter_if.slave  bus
);

  import wb_pkg::*;

  localparam int ENTRY_W = REG_ADDR_W + XLEN;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int STV_W   = $clog2(STARVE_MAX + 1);
  localparam logic [STV_W-1:0] STV_ONE = STV_W'(1);
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_MAX);

  wb_arb_state_e     r_state;
  wb_arb_state_e     w_state_nxt;
  logic [STV_W-1:0]  r_starve;
  logic [STV_W-1:0]  w_starve_nxt;
  logic [STV_W-1:0]  w_starve_inc;

  logic              r_we;
  logic [REG_ADDR_W-1:0] r_wreg;
  logic [XLEN-1:0]   r_wdata;

  logic [ENTRY_W-1:0] w_alu_entry;
  logic [ENTRY_W-1:0] w_lsu_entry;
  logic [ENTRY_W-1:0] w_fifo_head;
  logic [ENTRY_W-1:0] w_grant_entry;
  logic [CNT_W-1:0]   w_fifo_count;
  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic               w_push;
  logic               w_alu_slot;
  logic               w_grant_alu;
  logic               w_grant_fifo;
  logic               w_grant;

  assign w_alu_entry = {bus.alu_rd, bus.alu_data};
  assign w_lsu_entry = {bus.lsu_rd, bus.lsu_data};

  // Loads are accepted whenever there is room; a same-cycle pop does not
  // count as room because pushes never bypass the storage.
  assign bus.lsu_ready = rst_n && !w_fifo_full;
  assign w_push        = bus.lsu_valid && bus.lsu_ready;

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_lsu_entry),
    .i_pop       (w_grant_fifo),
    .o_head      (w_fifo_head),
    .o_count     (w_fifo_count),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full)
  );

  // Grant selection: forced/full FIFO head first, then ALU, then FIFO head.
  // w_alu_slot marks cycles where a valid ALU result would be taken, so
  // alu_ready does not wait on alu_valid.
  always_comb begin
    w_alu_slot   = 1'b0;
    w_grant_alu  = 1'b0;
    w_grant_fifo = 1'b0;
    if (rst_n) begin
      if ((w_fifo_full || r_state == LSU_FORCE) && !w_fifo_empty) begin
        w_grant_fifo = 1'b1;
      end else begin
        w_alu_slot = 1'b1;
        if (bus.alu_valid)      w_grant_alu  = 1'b1;
        else if (!w_fifo_empty) w_grant_fifo = 1'b1;
      end
    end
  end

  assign bus.alu_ready = w_alu_slot;
  assign w_grant       = w_grant_alu || w_grant_fifo;
  assign w_grant_entry = w_grant_fifo ? w_fifo_head : w_alu_entry;
  assign w_starve_inc  = r_starve + STV_ONE;

  // Starvation tracking: count ALU wins over a waiting load; on reaching
  // the limit spend exactly one cycle draining the FIFO head.
  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    case (r_state)
      ALU_PRI: begin
        if (w_grant_alu && !w_fifo_empty) begin
          w_starve_nxt = w_starve_inc;
          if (w_starve_inc == STV_MAX) w_state_nxt = LSU_FORCE;
        end else begin
          w_starve_nxt = '0;
        end
      end
      LSU_FORCE: begin
        w_state_nxt  = ALU_PRI;
        w_starve_nxt = '0;
      end
      default: begin
        w_state_nxt  = ALU_PRI;
        w_starve_nxt = '0;
      end
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ALU_PRI;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  // Registered write port; address/data hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_grant && wb_writes(w_grant_entry[ENTRY_W-1 -: REG_ADDR_W]);
      if (w_grant) begin
        r_wreg  <= w_grant_entry[ENTRY_W-1 -: REG_ADDR_W];
        r_wdata <= w_grant_entry[XLEN-1:0];
      end
    end
  end

  assign bus.write_enable = r_we;
  assign bus.write_reg    = r_wreg;
  assign bus.write_data   = r_wdata;
  assign bus.lsu_count    = w_fifo_count;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus randomized traffic,
// all checked against a queue-based model of the arbitration rules.
module tb_writeback_arbiter;

  import wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int SMAX  = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  writeback_arbiter_if #(.XLEN(32), .DEPTH(DEPTH)) bus();

  writeback_arbiter #(.XLEN(32), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  wb_entry_t q[$];
  bit        m_force;
  int        m_losses;

  // Per-cycle observations and expectations.
  logic        s_alu_rdy, s_lsu_rdy, s_we;
  logic [4:0]  s_reg;
  logic [31:0] s_data;
  logic [2:0]  s_cnt;
  logic        e_alu_rdy, e_lsu_rdy, e_we;
  logic [4:0]  e_reg;
  logic [31:0] e_data;
  logic [2:0]  e_cnt;
  logic        v_alu;

  // Advance one clock: sample readies before the edge, update the model,
  // sample the registered outputs after the edge.
  task automatic tick();
    wb_entry_t g;
    bit gv, from_fifo;
    int sz;
    #1;
    s_alu_rdy = bus.alu_ready;
    s_lsu_rdy = bus.lsu_ready;
    v_alu     = bus.alu_valid;
    sz        = q.size();
    e_lsu_rdy = rst_n && (sz < DEPTH);
    e_alu_rdy = rst_n && (sz < DEPTH) && !m_force;
    gv = 0; from_fifo = 0; g = '0;
    if (rst_n) begin
      if ((sz == DEPTH || m_force) && sz > 0) begin
        gv = 1; from_fifo = 1; g = q[0];
      end else if (bus.alu_valid) begin
        gv = 1; g.rd = bus.alu_rd; g.data = bus.alu_data;
      end else if (sz > 0) begin
        gv = 1; from_fifo = 1; g = q[0];
      end
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      q.delete();
      m_force = 0; m_losses = 0;
      e_we = 0; e_reg = '0; e_data = '0;
    end else begin
      e_we = gv && (g.rd != 5'd0);
      if (e_we) begin
        e_reg = g.rd; e_data = g.data;
      end
      if (m_force) begin
        m_force = 0; m_losses = 0;
      end else if (gv && !from_fifo && sz > 0) begin
        m_losses++;
        if (m_losses >= SMAX) m_force = 1;
      end else begin
        m_losses = 0;
      end
      if (from_fifo) void'(q.pop_front());
      if (bus.lsu_valid && e_lsu_rdy) q.push_back('{rd: bus.lsu_rd, data: bus.lsu_data});
    end
    e_cnt  = 3'(q.size());
    s_we   = bus.write_enable;
    s_reg  = bus.write_reg;
    s_data = bus.write_data;
    s_cnt  = bus.lsu_count;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 0; bus.lsu_rd = '0; bus.lsu_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    bus.alu_valid = 1; bus.alu_rd = 5'd4; bus.alu_data = 32'h1;
    bus.lsu_valid = 1; bus.lsu_rd = 5'd6; bus.lsu_data = 32'h2;
    tick();
    tick();
    n_vec++; if (s_alu_rdy !== 1'b0) begin n_err++; $display("FAIL reset_alu_ready: got %b expected 0", s_alu_rdy); end
    n_vec++; if (s_lsu_rdy !== 1'b0) begin n_err++; $display("FAIL reset_lsu_ready: got %b expected 0", s_lsu_rdy); end
    n_vec++; if (s_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b expected 0", s_we); end
    n_vec++; if (s_reg !== 5'd0 || s_data !== 32'd0) begin n_err++; $display("FAIL reset_wport: got reg %0d data %h expected 0/0", s_reg, s_data); end
    n_vec++; if (s_cnt !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", s_cnt); end
    idle_inputs();
    rst_n = 1;
  endtask

  task automatic test_alu_only();
    bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    tick();
    n_vec++; if (s_alu_rdy !== 1'b1) begin n_err++; $display("FAIL alu_only_ready: got %b expected 1", s_alu_rdy); end
    n_vec++; if (s_we !== 1'b1 || s_reg !== 5'd5 || s_data !== 32'hDEADBEEF)
      begin n_err++; $display("FAIL alu_only_write: got we %b reg %0d data %h expected 1/5/deadbeef", s_we, s_reg, s_data); end
    bus.alu_valid = 0;
    tick();
    n_vec++; if (s_we !== 1'b0 || s_reg !== 5'd5 || s_data !== 32'hDEADBEEF)
      begin n_err++; $display("FAIL alu_only_hold: got we %b reg %0d data %h expected 0/5/deadbeef", s_we, s_reg, s_data); end
  endtask

  task automatic test_lsu_only();
    bus.lsu_valid = 1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h12345678;
    tick();
    n_vec++; if (s_lsu_rdy !== 1'b1) begin n_err++; $display("FAIL lsu_only_ready: got %b expected 1", s_lsu_rdy); end
    n_vec++; if (s_cnt !== 3'd1 || s_we !== 1'b0) begin n_err++; $display("FAIL lsu_only_c1: got count %0d we %b expected 1/0", s_cnt, s_we); end
    bus.lsu_valid = 0;
    tick();
    n_vec++; if (s_we !== 1'b1 || s_reg !== 5'd7 || s_data !== 32'h12345678 || s_cnt !== 3'd0)
      begin n_err++; $display("FAIL lsu_only_c2: got we %b reg %0d data %h count %0d expected 1/7/12345678/0", s_we, s_reg, s_data, s_cnt); end
  endtask

  task automatic test_full_fifo();
    bus.alu_valid = 1; bus.alu_rd = 5'd2;
    for (int i = 0; i < DEPTH; i++) begin
      bus.alu_data = 32'hA000 + i;
      bus.lsu_valid = 1; bus.lsu_rd = 5'(10 + i); bus.lsu_data = 32'hB000 + i;
      tick();
      n_vec++; if (s_lsu_rdy !== 1'b1 || s_alu_rdy !== 1'b1)
        begin n_err++; $display("FAIL full_fill_ready: got lsu %b alu %b expected 1/1", s_lsu_rdy, s_alu_rdy); end
      n_vec++; if (s_we !== 1'b1 || s_reg !== 5'd2 || s_data !== 32'hA000 + i)
        begin n_err++; $display("FAIL full_fill_alu_write: got we %b reg %0d data %h", s_we, s_reg, s_data); end
    end
    n_vec++; if (s_cnt !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d expected 4", s_cnt); end
    bus.lsu_valid = 0;
    tick();
    n_vec++; if (s_lsu_rdy !== 1'b0 || s_alu_rdy !== 1'b0)
      begin n_err++; $display("FAIL full_ready: got lsu %b alu %b expected 0/0", s_lsu_rdy, s_alu_rdy); end
    n_vec++; if (s_we !== 1'b1 || s_reg !== 5'd10 || s_data !== 32'hB000 || s_cnt !== 3'd3)
      begin n_err++; $display("FAIL full_head_write: got we %b reg %0d data %h count %0d expected 1/10/b000/3", s_we, s_reg, s_data, s_cnt); end
    bus.alu_valid = 0;
    for (int i = 0; i < DEPTH + 2 && s_cnt != 3'd0; i++) begin
      tick();
      n_vec++; if (s_we !== e_we || (e_we && (s_reg !== e_reg || s_data !== e_data)) || s_cnt !== e_cnt)
        begin n_err++; $display("FAIL full_drain: got we %b reg %0d data %h count %0d expected %b/%0d/%h/%0d", s_we, s_reg, s_data, s_cnt, e_we, e_reg, e_data, e_cnt); end
    end
    n_vec++; if (s_cnt !== 3'd0) begin n_err++; $display("FAIL full_drained: got count %0d expected 0", s_cnt); end
  endtask

  task automatic test_starvation();
    bus.alu_valid = 1; bus.alu_rd = 5'd3; bus.alu_data = 32'hC0;
    bus.lsu_valid = 1; bus.lsu_rd = 5'd20; bus.lsu_data = 32'hA5A5A5A5;
    tick();
    bus.lsu_valid = 0;
    for (int i = 0; i < SMAX; i++) begin
      bus.alu_data = 32'(i);
      tick();
      n_vec++; if (s_alu_rdy !== 1'b1 || s_we !== 1'b1 || s_reg !== 5'd3 || s_data !== 32'(i))
        begin n_err++; $display("FAIL starve_alu_%0d: got rdy %b we %b reg %0d data %h", i, s_alu_rdy, s_we, s_reg, s_data); end
    end
    bus.alu_data = 32'hEE;
    tick();
    n_vec++; if (s_alu_rdy !== 1'b0 || s_we !== 1'b1 || s_reg !== 5'd20 || s_data !== 32'hA5A5A5A5)
      begin n_err++; $display("FAIL starve_forced: got rdy %b we %b reg %0d data %h expected 0/1/20/a5a5a5a5", s_alu_rdy, s_we, s_reg, s_data); end
    tick();
    n_vec++; if (s_alu_rdy !== 1'b1 || s_we !== 1'b1 || s_reg !== 5'd3 || s_data !== 32'hEE || s_cnt !== 3'd0)
      begin n_err++; $display("FAIL starve_resume: got rdy %b we %b reg %0d data %h count %0d", s_alu_rdy, s_we, s_reg, s_data, s_cnt); end
    idle_inputs();
  endtask

  task automatic test_rd_zero();
    bus.alu_valid = 1; bus.alu_rd = 5'd0; bus.alu_data = 32'h11;
    bus.lsu_valid = 1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'h22;
    tick();
    n_vec++; if (s_alu_rdy !== 1'b1 || s_lsu_rdy !== 1'b1)
      begin n_err++; $display("FAIL rd0_handshake: got alu %b lsu %b expected 1/1", s_alu_rdy, s_lsu_rdy); end
    n_vec++; if (s_we !== 1'b0 || s_cnt !== 3'd1) begin n_err++; $display("FAIL rd0_c1: got we %b count %0d expected 0/1", s_we, s_cnt); end
    idle_inputs();
    tick();
    n_vec++; if (s_we !== 1'b0 || s_cnt !== 3'd0) begin n_err++; $display("FAIL rd0_c2: got we %b count %0d expected 0/0", s_we, s_cnt); end
    tick();
    n_vec++; if (s_we !== 1'b0) begin n_err++; $display("FAIL rd0_c3: got we %b expected 0", s_we); end
  endtask

  task automatic test_reset_mid();
    bus.alu_valid = 1; bus.alu_rd = 5'd9; bus.alu_data = $urandom;
    for (int i = 0; i < 3; i++) begin
      bus.lsu_valid = 1; bus.lsu_rd = 5'(i + 1); bus.lsu_data = $urandom;
      tick();
    end
    n_vec++; if (s_cnt !== 3'd3) begin n_err++; $display("FAIL rstmid_fill: got count %0d expected 3", s_cnt); end
    bus.lsu_valid = 0;
    rst_n = 0;
    tick();
    n_vec++; if (s_alu_rdy !== 1'b0 || s_lsu_rdy !== 1'b0)
      begin n_err++; $display("FAIL rstmid_ready: got alu %b lsu %b expected 0/0", s_alu_rdy, s_lsu_rdy); end
    n_vec++; if (s_cnt !== 3'd0 || s_we !== 1'b0) begin n_err++; $display("FAIL rstmid_clear: got count %0d we %b expected 0/0", s_cnt, s_we); end
    rst_n = 1;
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++; if (s_we !== 1'b0 || s_cnt !== 3'd0) begin n_err++; $display("FAIL rstmid_stale: got we %b count %0d expected 0/0", s_we, s_cnt); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n         = ($urandom_range(0, 99) != 0);
      bus.alu_valid = ($urandom_range(0, 3) != 0);
      bus.alu_rd    = 5'($urandom_range(0, 31));
      bus.alu_data  = $urandom;
      bus.lsu_valid = ($urandom_range(0, 1) != 0);
      bus.lsu_rd    = 5'($urandom_range(0, 31));
      bus.lsu_data  = $urandom;
      tick();
      if (v_alu) begin
        n_vec++; if (s_alu_rdy !== e_alu_rdy) begin n_err++; $display("FAIL rand_alu_ready c%0d: got %b expected %b", c, s_alu_rdy, e_alu_rdy); end
      end
      n_vec++; if (s_lsu_rdy !== e_lsu_rdy) begin n_err++; $display("FAIL rand_lsu_ready c%0d: got %b expected %b", c, s_lsu_rdy, e_lsu_rdy); end
      n_vec++; if (s_we !== e_we) begin n_err++; $display("FAIL rand_we c%0d: got %b expected %b", c, s_we, e_we); end
      if (e_we) begin
        n_vec++; if (s_reg !== e_reg || s_data !== e_data)
          begin n_err++; $display("FAIL rand_wport c%0d: got reg %0d data %h expected %0d/%h", c, s_reg, s_data, e_reg, e_data); end
      end
      n_vec++; if (s_cnt !== e_cnt) begin n_err++; $display("FAIL rand_count c%0d: got %0d expected %0d", c, s_cnt, e_cnt); end
    end
    rst_n = 1;
    idle_inputs();
  endtask

  initial begin
    m_force = 0; m_losses = 0;
    e_we = 0; e_reg = '0; e_data = '0; e_cnt = '0;
    idle_inputs();
    test_reset();
    test_alu_only();
    test_lsu_only();
    test_full_fifo();
    test_starvation();
    test_rd_zero();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
